// File: rtl/rx_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sample_fifo
//  Description : 64-bit RX sample FIFO with a 32-bit read side. Samples go in
//                whole and come out as two 32-bit words, low half first.
//                Sticky overflow/underflow flags, flush and clear controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sample_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // Sample input from the RX chain
  input  logic [63:0]             s_axis_tdata_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  // 32-bit read side
  input  logic                    rd_en_i,
  output logic [31:0]             rd_data_o,
  output logic                    rd_valid_o,
  output logic [DEPTH_LOG2+1:0]   fill_o,
  // Status and control
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    clr_flags_i,
  input  logic                    flush_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int FILL_W = DEPTH_LOG2 + 2;
  localparam logic [PTR_W-1:0] C_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Sample storage; no reset so it maps onto distributed RAM
  logic [63:0] mem [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  // 0: next read returns bits [31:0]; 1: next read returns bits [63:32]
  logic             r_half;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [PTR_W-1:0]  w_count;
  logic [FILL_W-1:0] w_fill;
  logic              w_tready;
  logic              w_not_empty;
  logic              w_wr_accept;
  logic              w_wr_drop;
  logic              w_rd_accept;
  logic              w_rd_empty;
  logic              w_pop;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [63:0]       w_rd_entry;

  // Occupancy and handshake terms, all derived from registered state
  always_comb begin
    w_count     = r_wr_ptr - r_rd_ptr;
    w_fill      = {w_count, 1'b0} - {{(FILL_W-1){1'b0}}, r_half};
    // The count never exceeds DEPTH, so its top bit alone marks "full"
    w_tready    = ~w_count[DEPTH_LOG2];
    w_not_empty = (w_fill != '0);
  end

  // Per-cycle transaction decode; flush overrides any write or read
  always_comb begin
    w_wr_accept = s_axis_tvalid_i & w_tready & ~flush_i;
    w_wr_drop   = s_axis_tvalid_i & ~w_tready & ~flush_i;
    w_rd_accept = rd_en_i & w_not_empty & ~flush_i;
    w_rd_empty  = rd_en_i & ~w_not_empty & ~flush_i;
    w_pop       = w_rd_accept & r_half;
    w_wr_addr   = r_wr_ptr[DEPTH_LOG2-1:0];
    w_rd_addr   = r_rd_ptr[DEPTH_LOG2-1:0];
    w_rd_entry  = mem[w_rd_addr];
  end

  // Synchronous-write storage array
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      mem[w_wr_addr] <= s_axis_tdata_i;
    end
  end

  // Write pointer: advances on accepted samples, zeroed by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
    end
  end

  // Read pointer and half-select: pop the entry after its upper half is read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_half   <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_half   <= 1'b0;
    end else if (w_rd_accept) begin
      r_half <= ~r_half;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

  // Read data path: one-cycle latency, data holds when no word is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data <= r_half ? w_rd_entry[63:32] : w_rd_entry[31:0];
      end
    end
  end

  // Sticky flags: a new event wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_flags_i) begin
        r_overflow <= 1'b0;
      end
      if (w_rd_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_flags_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign s_axis_tready_o = w_tready;
  assign rd_data_o       = r_rd_data;
  assign rd_valid_o      = r_rd_valid;
  assign fill_o          = w_fill;
  assign overflow_o      = r_overflow;
  assign underflow_o     = r_underflow;

endmodule
`default_nettype wire

// File: doc/rx_sample_fifo.md
RX_SAMPLE_FIFO -- requirements
Module: rx_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4; FIFO depth = 2^DEPTH_LOG2 entries of 64 bits.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata_i  in  64  RX sample from RX chain; {I/Q word high, I/Q word low}.
- s_axis_tvalid_i  in  1  sample valid, single-cycle pulse per sample.
- s_axis_tready_o  out  1  FIFO can accept a sample this cycle.
- rd_en_i  in  1  read strobe; requests one 32-bit word.
- rd_data_o  out  32  read data word.
- rd_valid_o  out  1  rd_data_o carries a word produced by the previous cycle's rd_en_i.
- fill_o  out  DEPTH_LOG2+2  32-bit words currently readable.
- overflow_o  out  1  sticky: a sample was dropped.
- underflow_o  out  1  sticky: a read was attempted while empty.
- clr_flags_i  in  1  clears overflow_o and underflow_o.
- flush_i  in  1  discards all stored data.

Function
REQ-003 s_axis_tready_o SHALL be 1 iff entry count < 2^DEPTH_LOG2, derived from registered state only (no combinational path from inputs).
REQ-004 When s_axis_tvalid_i=1 and s_axis_tready_o=1, the 64-bit sample SHALL be written at the write pointer, and the pointer SHALL advance by 1 modulo depth.
REQ-005 When s_axis_tvalid_i=1 and s_axis_tready_o=0, the sample SHALL be dropped, FIFO contents SHALL be unchanged, and overflow_o SHALL be set to 1 on the next cycle. The upstream stage ignores tready, so dropping is the defined behaviour.
REQ-006 Reads SHALL be in 32-bit halves: the first read of an entry returns bits [31:0], the second returns bits [63:32]. A half-select register tracks the position.
REQ-007 On rd_en_i=1 with fill_o>0 at cycle N:
- rd_data_o SHALL update and rd_valid_o SHALL be 1 at cycle N+1 (latency 1).
- On an upper-half read, the entry SHALL be popped and the read pointer SHALL advance modulo depth.
REQ-008 On rd_en_i=1 with fill_o=0:
- rd_valid_o SHALL be 0 next cycle.
- rd_data_o SHALL hold its previous value.
- underflow_o SHALL be set.
- No pointer or half-select change.
REQ-009 rd_valid_o SHALL be 0 in any cycle not following an accepted read.
REQ-010 fill_o SHALL equal 2*entries - half_select. It SHALL update one cycle after the write or read that changes it.
REQ-011 Simultaneous write and pop in the same cycle:
- Not full: both SHALL take effect and entry count is unchanged.
- Full: tready=0 already, so the write is dropped (REQ-005) and the pop proceeds.
REQ-012 Writing into an empty FIFO: the word SHALL be readable via rd_en_i no earlier than the cycle after the write (fill_o>0).
REQ-013 Pointers SHALL be DEPTH_LOG2+1 bits to distinguish full from empty. Wrap-around SHALL be transparent to data order.
REQ-014 flush_i=1 SHALL on the next edge:
- Zero both pointers and the half-select.
- Suppress any same-cycle write or read; rd_valid_o=0.
- Leave the sticky flags unchanged.
REQ-015 clr_flags_i=1 SHALL clear both flags on the next edge. If a new overflow/underflow occurs in the same cycle, the set SHALL take priority.
REQ-016 Storage SHALL be a simple synchronous-write array, inferable as distributed RAM. Storage contents are not reset.

Reset
REQ-017 While rst=1, asynchronously:
- Pointers, half-select and entry count = 0.
- rd_data_o=0, rd_valid_o=0, fill_o=0, overflow_o=0, underflow_o=0.
- s_axis_tready_o=1.
REQ-018 Reset asserted mid-operation SHALL discard all stored data. After release, the first sample written SHALL be the first word read.

Verification
REQ-019 Write 0x11112222_33334444 once, then rd_en_i on two consecutive cycles -> rd_data_o=0x33334444 then 0x11112222, rd_valid_o=1 on both; fill_o 2->1->0.
REQ-020 Write 17 samples back-to-back with DEPTH_LOG2=4 and no reads -> tready falls after the 16th; the 17th is dropped; overflow_o=1; fill_o=32; 32 reads return samples 1-16 in order.
REQ-021 rd_en_i on an empty FIFO -> rd_valid_o=0, underflow_o=1, rd_data_o unchanged. Then clr_flags_i -> both flags 0.
REQ-022 Fill to 16 entries, then write and read simultaneously on an upper-half read -> write dropped (overflow set), entry count 15. At 15 entries, simultaneous write and pop -> count stays 15, overflow not set.
REQ-023 Stream 40 samples interleaved with reads (pointer wrap twice) -> read sequence is an exact ordered match; no flags set.
REQ-024 Assert rst for 1 cycle after 5 writes and 3 reads -> all outputs at reset values; the next written sample is read back first, low half.
